// File: rtl/dff_pipe_pkg.sv
// Shared helpers for the dff_pipe elastic register pipeline.
package dff_pipe_pkg;

   // Width of an occupancy count that must represent 0..depth inclusive.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One dff_pipe stage: valid bit plus data register with load enable and synchronous clear.
module dff_pipe_stage
   import dff_pipe_pkg::*;
#(
   parameter int unsigned          width_p     = 8,
   parameter logic [width_p-1:0]   reset_val_p = '0
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               clear_i,
   input  logic               load_i,
   input  logic               v_i,
   input  logic [width_p-1:0] d_i,
   output logic               v_o,
   output logic [width_p-1:0] d_o
);

   logic               v_q;
   logic [width_p-1:0] d_q;

   // Clear only drops the valid bit; data is left as-is.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_q <= 1'b0;
         d_q <= reset_val_p;
      end else begin
         if (clear_i) begin
            v_q <= 1'b0;
         end else if (load_i) begin
            v_q <= v_i;
         end
         if (load_i && !clear_i) begin
            d_q <= d_i;
         end
      end
   end

   assign v_o = v_q;
   assign d_o = d_q;

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: depth_p-stage elastic register pipeline with valid/ready on both ends.
// Define DFF_PIPE_COUNT_EN to add the registered occupancy counter on count_o.
module dff_pipe
   import dff_pipe_pkg::*;
#(
   parameter int unsigned          width_p     = 8,
   parameter int unsigned          depth_p     = 4,
   parameter logic [width_p-1:0]   reset_val_p = '0
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               flush_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [width_p-1:0] data_o
`ifdef DFF_PIPE_COUNT_EN
   ,
   output logic [count_width(depth_p)-1:0] count_o
`endif
);

   logic [depth_p-1:0] v_q;
   logic [width_p-1:0] d_q [depth_p];
   logic [depth_p:0]   rdy;

   // A stage can load if it is empty or its downstream neighbour is loading too.
   always_comb begin
      rdy          = '0;
      rdy[depth_p] = ready_i;
      for (int k = int'(depth_p) - 1; k >= 0; k--) begin
         rdy[k] = !v_q[k] || rdy[k+1];
      end
   end

   assign ready_o = rdy[0] && !flush_i;

   for (genvar k = 0; k < depth_p; k++) begin : g_stage
      logic               v_in;
      logic [width_p-1:0] d_in;

      if (k == 0) begin : g_head
         assign v_in = valid_i && ready_o;
         assign d_in = data_i;
      end else begin : g_body
         assign v_in = v_q[k-1];
         assign d_in = d_q[k-1];
      end

      dff_pipe_stage #(
         .width_p     (width_p),
         .reset_val_p (reset_val_p)
      ) u_stage (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .clear_i   (flush_i),
         .load_i    (rdy[k]),
         .v_i       (v_in),
         .d_i       (d_in),
         .v_o       (v_q[k]),
         .d_o       (d_q[k])
      );
   end

   assign valid_o = v_q[depth_p-1];
   assign data_o  = d_q[depth_p-1];

`ifdef DFF_PIPE_COUNT_EN
   localparam int unsigned count_w_lp = count_width(depth_p);

   logic                  xfer_in;
   logic                  xfer_out;
   logic [count_w_lp-1:0] count_q;
   logic [count_w_lp-1:0] count_d;

   assign xfer_in  = valid_i && ready_o;
   assign xfer_out = valid_o && ready_i;

   // Flush wins over a same-cycle output transfer.
   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else if (xfer_in && !xfer_out) begin
         count_d = count_q + count_w_lp'(1);
      end else if (!xfer_in && xfer_out) begin
         count_d = count_q - count_w_lp'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
`endif

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised successor to the single-bit enabled DFF: a `depth_p`-stage, `width_p`-bit register pipeline with per-stage valid bits and a valid/ready handshake on both ends. Stalled stages hold their data, and bubbles collapse. A synchronous flush empties the pipeline. The block is a drop-in retiming and elastic-buffer element for datapaths that previously chained bare `dff` instances with a shared enable.

## Interface
- `width_p`, default 8: data width in bits, minimum 1.
- `depth_p`, default 4: number of register stages, minimum 1.
- `reset_val_p`, default `'0`: value loaded into every data register on reset.

- `clk_i`  in  1  the single clock; all state updates on posedge.
- `reset_n_i`  in  1  reset, asynchronous and active-low.
- `flush_i`  in  1  synchronous flush; clears all valid bits at the next edge.
- `valid_i`  in  1  upstream data valid.
- `ready_o`  out  1  block can accept this cycle.
- `data_i`  in  `width_p`  upstream data.
- `valid_o`  out  1  output stage holds valid data.
- `ready_i`  in  1  downstream accepts this cycle.
- `data_o`  out  `width_p`  output stage data.
- `count_o`  out  `$clog2(depth_p+1)`  number of occupied stages. Present only with `DFF_PIPE_COUNT_EN`.

## Operation
- Stage index k runs from 0 to `depth_p`-1. Stage 0 is the input side; stage `depth_p`-1 drives `valid_o`/`data_o`.
- Each stage holds `v[k]` and `d[k]`.
- Per-stage ready: `rdy[k] = !v[k] || rdy[k+1]`, with `rdy[depth_p] = ready_i`.
- `ready_o = rdy[0] && !flush_i`.
- Stage k loads when `rdy[k]` is 1:
  - `v[k] <= v[k-1]` and `d[k] <= d[k-1]`.
  - Stage 0 takes `valid_i && ready_o` and `data_i`.
- Stages with `rdy[k]` = 0 hold both `v` and `d` (stall).
- An empty stage accepts from upstream even while downstream is stalled. Bubbles therefore collapse, and a full pipeline with `ready_i` = 0 holds exactly `depth_p` items.
- Transfer in: `valid_i && ready_o`. Transfer out: `valid_o && ready_i`.
- Data order is strictly FIFO. Nothing is duplicated or dropped, except on flush.
- `flush_i` = 1:
  - All `v[k]` go to 0 at the next edge; `d[k]` are unchanged.
  - `ready_o` = 0, so no input is accepted that cycle.
  - An output transfer in the flush cycle still counts as delivered.
- Reset (`reset_n_i` = 0), taking effect immediately and independent of the clock:
  - All `v[k]` = 0 and all `d[k]` = `reset_val_p`.
  - Therefore `valid_o` = 0 and `data_o` = `reset_val_p`.
  - `ready_o` follows `rdy[0]`, which is 1 once the pipeline is empty.
- Reset asserted mid-stream discards all contents. The first accept after deassertion behaves as for an empty pipeline.

## Timing
- Latency: with the pipeline empty and `ready_i` held at 1, an item accepted at edge N appears on `valid_o` after edge N+`depth_p`-1. That is `depth_p` register stages, counting the stage-0 load.
- Throughput is 1 item per cycle when `ready_i` = 1.
- `ready_o` is combinational from `ready_i` through a chain of `depth_p` ANDs/ORs; this is the timing-critical path.
- `valid_o` and `data_o` are direct register outputs.
- Removing reset mid-cycle needs no special handling; the first posedge after deassertion is a normal edge.

## Configuration
- Macro `DFF_PIPE_COUNT_EN`.
- Defined:
  - A registered occupancy counter drives `count_o`.
  - Each cycle it adds 1 for a transfer in and subtracts 1 for a transfer out; both in the same cycle leave it unchanged.
  - It resets to 0 and goes to 0 on flush. A transfer out in the flush cycle does not affect the 0 result.
  - It must always equal the number of set `v[k]` bits; the bench checks this every cycle.
- Undefined: no `count_o` port and no counter logic. Behaviour is otherwise identical.

## Structure
- No new shared typedefs.
- Count width is computed in the shared package as function `dff_pipe_pkg::count_width(depth)`, returning `$clog2(depth+1)`, for reuse by consumers.
- Sub-module `dff_pipe_stage`, instantiated `depth_p` times:
  - Contains one stage's `v`/`d` registers, async active-low reset, load enable, and synchronous clear.
  - The top module holds the ready chain, flush gating, and the optional counter.

## Test plan
Run with `width_p`=8, `depth_p`=4, `reset_val_p`=8'hA5.
- Reset: hold `reset_n_i`=0 -> `valid_o`=0, `data_o`=8'hA5, `ready_o`=1, `count_o`=0.
- Streaming: `ready_i`=1, push 8'h01..8'h10 on consecutive cycles -> first `valid_o` 4 edges after the first accept, then 16 consecutive outputs in order, no gaps.
- Stall and fill: `ready_i`=0, push continuously -> exactly 4 accepts, then `ready_o`=0 and `count_o`=4. Raise `ready_i` -> `ready_o`=1 in the same cycle, and 01,02,03,04 drain in order.
- Bubble collapse: push 8'h11, idle 2 cycles, push 8'h22 with `ready_i`=0 throughout -> both items end up in stages 3 and 2, `count_o`=2.
- Flush: with 3 items stored, assert `flush_i` for 1 cycle with `valid_i`=1 -> `ready_o`=0 that cycle, then `valid_o`=0, `count_o`=0, and the next push has full 4-cycle latency.
- Async reset mid-stream: drop `reset_n_i` between edges while full -> `valid_o` falls before the next edge. After release, the pipe is empty and data values are 8'hA5.
